// File: rtl/sb_cfg_pkg.sv
// Shared constants and types for the switch-box configuration loader.
// Side codes, geometry, entry bases and the loader FSM state encoding.
package sb_cfg_pkg;

    localparam int N_TB  = 5;
    localparam int N_LR  = 4;
    localparam int CFG_W = 6;
    localparam int N_ENT = 2 * N_TB + 2 * N_LR;
    localparam int CNT_W = 5;

    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    localparam int TOP_BASE   = 0;
    localparam int BOT_BASE   = TOP_BASE + N_TB;
    localparam int LEFT_BASE  = BOT_BASE + N_TB;
    localparam int RIGHT_BASE = LEFT_BASE + N_LR;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/sb_cfg_word_check.sv
// Combinational legality check of one routing word against its entry.
// Rejects bad side codes, out-of-range indices and self-loops.
module sb_cfg_word_check
    import sb_cfg_pkg::SIDE_NONE, sb_cfg_pkg::SIDE_TOP,
           sb_cfg_pkg::SIDE_RIGHT, sb_cfg_pkg::SIDE_BOTTOM,
           sb_cfg_pkg::SIDE_LEFT, sb_cfg_pkg::CNT_W;
#(
    parameter int N_TB  = 5,
    parameter int N_LR  = 4,
    parameter int CFG_W = 6
) (
    input  logic [CFG_W-1:0] word,
    input  logic [CNT_W-1:0] idx,
    output logic             legal
);

    localparam int BOT0   = N_TB;
    localparam int LEFT0  = 2 * N_TB;
    localparam int RIGHT0 = 2 * N_TB + N_LR;

    logic [2:0] src_side;
    logic [2:0] dst_side;
    int         src_idx;
    int         dst_idx;
    int         k;

    assign src_side = word[2:0];

    // Decode the destination wire, then test range and self-loop.
    always_comb begin
        legal    = 1'b0;
        k        = int'(idx);
        src_idx  = int'(word[CFG_W-1:3]);
        dst_side = SIDE_TOP;
        dst_idx  = k;
        if (k >= RIGHT0) begin
            dst_side = SIDE_RIGHT;
            dst_idx  = k - RIGHT0;
        end else if (k >= LEFT0) begin
            dst_side = SIDE_LEFT;
            dst_idx  = k - LEFT0;
        end else if (k >= BOT0) begin
            dst_side = SIDE_BOTTOM;
            dst_idx  = k - BOT0;
        end
        unique case (src_side)
            SIDE_NONE:               legal = 1'b1;
            SIDE_TOP, SIDE_BOTTOM:   legal = (src_idx < N_TB);
            SIDE_RIGHT, SIDE_LEFT:   legal = (src_idx < N_LR);
            default:                 legal = 1'b0;
        endcase
        if (src_side != SIDE_NONE && src_side == dst_side &&
            src_idx == dst_idx) begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/sb_config_loader.sv
// Framed configuration loader for the switch-box select bus.
// Shadow-buffers a frame and commits it only when complete and legal.
module sb_config_loader
    import sb_cfg_pkg::state_t, sb_cfg_pkg::S_IDLE, sb_cfg_pkg::S_LOAD,
           sb_cfg_pkg::S_COMMIT, sb_cfg_pkg::S_DRAIN, sb_cfg_pkg::CNT_W;
#(
    parameter int N_TB  = sb_cfg_pkg::N_TB,
    parameter int N_LR  = sb_cfg_pkg::N_LR,
    parameter int CFG_W = sb_cfg_pkg::CFG_W,
    localparam int N_ENT = 2 * N_TB + 2 * N_LR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CFG_W-1:0]       cfg_data,
    input  logic                   cfg_last,
    output logic [N_ENT*CFG_W-1:0] cfg_bus,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic                   cfg_loaded
);

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d, widx;
    logic [N_ENT*CFG_W-1:0] shadow, bus_q;
    logic                   ready_q, err_q, err_d, done_q, loaded_q;
    logic                   accept, legal, at_end, frame_ok, frame_err;
    logic                   filling;

    assign accept    = cfg_valid && ready_q;
    assign filling   = (state == S_IDLE) || (state == S_LOAD);
    assign widx      = (state == S_IDLE) ? '0 : cnt;
    assign at_end    = (widx == CNT_W'(N_ENT - 1));
    assign frame_ok  = legal && at_end && cfg_last;
    assign frame_err = !legal || (cfg_last != at_end);

    assign cfg_ready  = ready_q;
    assign cfg_bus    = bus_q;
    assign cfg_done   = done_q;
    assign cfg_err    = err_q;
    assign cfg_loaded = loaded_q;

    sb_cfg_word_check #(
        .N_TB  (N_TB),
        .N_LR  (N_LR),
        .CFG_W (CFG_W)
    ) u_check (
        .word  (cfg_data),
        .idx   (widx),
        .legal (legal)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, word counter and sticky error.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        err_d   = err_q;
        unique case (state)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (state == S_IDLE) begin
                        err_d = 1'b0;
                    end
                    cnt_d   = widx + 1'b1;
                    state_d = S_LOAD;
                    if (frame_ok) begin
                        cnt_d   = '0;
                        state_d = S_COMMIT;
                    end else if (frame_err) begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = cfg_last ? S_IDLE : S_DRAIN;
                    end
                end
            end
            S_COMMIT: state_d = S_IDLE;
            S_DRAIN: begin
                if (accept && cfg_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shadow fill, atomic commit and registered handshake/status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            shadow   <= '0;
            bus_q    <= '0;
            ready_q  <= 1'b1;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            err_q   <= err_d;
            ready_q <= (state_d != S_COMMIT);
            done_q  <= (state == S_COMMIT);
            if (accept && filling) begin
                shadow[int'(widx)*CFG_W +: CFG_W] <= cfg_data;
            end
            if (state == S_COMMIT) begin
                bus_q    <= shadow;
                loaded_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sb_config_loader.sv
// Directed self-checking bench for the switch-box config loader.
// Expected buses are built from the bench's own frame tables.
module tb_sb_config_loader;

    localparam int W  = 6;
    localparam int NE = 18;
    localparam int BW = NE * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  cfg_data;
    logic          cfg_last;
    logic [BW-1:0] cfg_bus;
    logic          cfg_done;
    logic          cfg_err;
    logic          cfg_loaded;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    int d0;

    logic [W-1:0]  fw [0:18];
    logic [BW-1:0] exp_a, exp_c, exp_d;

    always #5 clk = ~clk;

    sb_config_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .cfg_last   (cfg_last),
        .cfg_bus    (cfg_bus),
        .cfg_done   (cfg_done),
        .cfg_err    (cfg_err),
        .cfg_loaded (cfg_loaded)
    );

    // Count commit pulses just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (cfg_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input logic l);
        int t = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        while (cfg_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        compared++;
        assert (t < 20) else begin
            mismatched++;
            $error("FAIL ready_timeout: observed %b expected 1", cfg_ready);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi,
                              input int lastidx, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            send(fw[i], i == lastidx);
            if (gaps && i != hi) begin
                int g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    chk("ready_gap", cfg_ready, 1);
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic fill_base();
        for (int k = 0; k < 19; k++) fw[k] = 6'o01;
        fw[0] = 6'o13;
    endtask

    function automatic logic [BW-1:0] pack();
        logic [BW-1:0] v = '0;
        for (int k = 0; k < NE; k++) v[k*W +: W] = fw[k];
        return v;
    endfunction

    task automatic commit_check(input string tag, input logic [BW-1:0] exp,
                                input logic [BW-1:0] prev);
        int c0 = done_cnt;
        chk({tag, "_ready_low"}, cfg_ready, 0);
        chk({tag, "_done_early"}, cfg_done, 0);
        chk({tag, "_bus_hold"}, cfg_bus, prev);
        @(negedge clk);
        chk({tag, "_done"}, cfg_done, 1);
        chk({tag, "_bus"}, cfg_bus, exp);
        chk({tag, "_loaded"}, cfg_loaded, 1);
        chk({tag, "_ready_back"}, cfg_ready, 1);
        chk({tag, "_err"}, cfg_err, 0);
        @(negedge clk);
        chk({tag, "_done_off"}, cfg_done, 0);
        chk({tag, "_done_once"}, done_cnt - c0, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_bus", cfg_bus, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_loaded", cfg_loaded, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", cfg_ready, 1);

        // Legal base frame
        fill_base();
        exp_a = pack();
        send_range(0, 17, 17, 0);
        commit_check("t1", exp_a, '0);
        chk("t1_entry0", cfg_bus[5:0], 6'o13);

        // Illegal side code at entry 6, then drained
        fill_base();
        fw[6] = 6'o05;
        d0 = done_cnt;
        send_range(0, 6, 99, 0);
        chk("t2_err", cfg_err, 1);
        send_range(7, 7, 99, 0);
        chk("t2_drain_err", cfg_err, 1);
        send_range(8, 17, 17, 0);
        chk("t2_err_end", cfg_err, 1);
        chk("t2_ready", cfg_ready, 1);
        @(negedge clk);
        chk("t2_no_done", done_cnt - d0, 0);
        chk("t2_bus_kept", cfg_bus, exp_a);

        // left[2] <- right[2] legal, then left[2] <- left[2] loop
        fill_base();
        fw[12] = 6'o22;
        exp_c = pack();
        send_range(0, 17, 17, 0);
        commit_check("t3a", exp_c, exp_a);
        fw[12] = 6'o24;
        d0 = done_cnt;
        send_range(0, 11, 99, 0);
        chk("t3b_err_pre", cfg_err, 0);
        send_range(12, 12, 99, 0);
        chk("t3b_err", cfg_err, 1);
        send_range(13, 17, 17, 0);
        @(negedge clk);
        chk("t3b_bus_kept", cfg_bus, exp_c);
        chk("t3b_no_done", done_cnt - d0, 0);

        // Short frame, long frame, then recovery
        fill_base();
        d0 = done_cnt;
        send_range(0, 16, 16, 0);
        chk("t4_short_err", cfg_err, 1);
        chk("t4_short_ready", cfg_ready, 1);
        send_range(0, 0, 99, 0);
        chk("t4_idle_clear", cfg_err, 0);
        send_range(1, 17, 99, 0);
        chk("t4_long_err", cfg_err, 1);
        send_range(18, 18, 18, 0);
        chk("t4_long_ready", cfg_ready, 1);
        chk("t4_long_err2", cfg_err, 1);
        @(negedge clk);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_bus_kept", cfg_bus, exp_c);
        send_range(0, 0, 99, 0);
        chk("t4_recover_clear", cfg_err, 0);
        send_range(1, 17, 17, 0);
        commit_check("t4c", exp_a, exp_c);

        // Gapped valid on a legal frame
        fill_base();
        fw[17] = 6'o21;
        exp_d = pack();
        send_range(0, 17, 17, 1);
        commit_check("t5", exp_d, exp_a);

        // Reset mid-frame after nine words
        fill_base();
        fw[3] = 6'o22;
        send_range(0, 8, 99, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_bus", cfg_bus, 0);
        chk("t6_rst_ready", cfg_ready, 1);
        chk("t6_rst_done", cfg_done, 0);
        chk("t6_rst_err", cfg_err, 0);
        chk("t6_rst_loaded", cfg_loaded, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_base();
        send_range(0, 17, 17, 0);
        commit_check("t6", exp_a, '0);

        chk("total_done", done_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
